// File: rtl/axi4_handshake_monitor_if.sv
// AXI4 five-channel signal bundle for one master/slave link.
// The monitor modport observes every wire and drives none.
interface axi4_handshake_monitor_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  localparam int INFO_W = ID_WIDTH + ADDR_WIDTH + 28;

  logic                  awvalid;
  logic                  awready;
  logic [INFO_W-1:0]     awinfo;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [INFO_W-1:0]     arinfo;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awinfo, wvalid, wlast, wdata, wstrb,
    output bready, arvalid, arinfo, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rlast, rid, rdata, rresp
  );

  modport slave (
    input  awvalid, awinfo, wvalid, wlast, wdata, wstrb,
    input  bready, arvalid, arinfo, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rlast, rid, rdata, rresp
  );

  modport monitor (
    input awvalid, awready, awinfo,
    input wvalid, wready, wlast, wdata, wstrb,
    input bvalid, bready, bid, bresp,
    input arvalid, arready, arinfo,
    input rvalid, rready, rlast, rid, rdata, rresp
  );
endinterface

// File: rtl/axi4_handshake_monitor.sv
// Passive AXI4 observer: per-channel handshake counters and
// sticky VALID/payload stability violation flags.
module axi4_hs_cnt #(
  parameter int CW = 32
) (
  input  logic          aclk,
  input  logic          areset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + ONE;
    end
  end
endmodule

module axi4_chan_chk #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         areset_n,
  input  logic         clr,
  input  logic         valid,
  input  logic         ready,
  input  logic [W-1:0] payload,
  output logic         viol
);
  logic         pend;
  logic [W-1:0] snap;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      pend <= 1'b0;
      snap <= '0;
      viol <= 1'b0;
    end else begin
      snap <= payload;
      if (clr) begin
        pend <= 1'b0;
        viol <= 1'b0;
      end else begin
        pend <= valid & ~ready;
        // unknown compare results leave the flag untouched
        if (pend && (!valid || payload != snap)) begin
          viol <= 1'b1;
        end
      end
    end
  end
endmodule

module axi4_handshake_monitor #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          clr,
  axi4_handshake_monitor_if.monitor     bus,
  output logic [CNT_WIDTH-1:0]          aw_count,
  output logic [CNT_WIDTH-1:0]          w_count,
  output logic [CNT_WIDTH-1:0]          w_last_count,
  output logic [CNT_WIDTH-1:0]          b_count,
  output logic [CNT_WIDTH-1:0]          ar_count,
  output logic [CNT_WIDTH-1:0]          r_count,
  output logic [CNT_WIDTH-1:0]          r_last_count,
  output logic [4:0]                    violation
);
  localparam int INFO_W = ID_WIDTH + ADDR_WIDTH + 28;
  localparam int WP_W   = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int BP_W   = ID_WIDTH + 2;
  localparam int RP_W   = ID_WIDTH + DATA_WIDTH + 3;

  logic [6:0]           inc;
  logic [CNT_WIDTH-1:0] cnt [7];

  assign inc = {
    bus.rvalid  & bus.rready & bus.rlast,
    bus.rvalid  & bus.rready,
    bus.arvalid & bus.arready,
    bus.bvalid  & bus.bready,
    bus.wvalid  & bus.wready & bus.wlast,
    bus.wvalid  & bus.wready,
    bus.awvalid & bus.awready
  };

  for (genvar i = 0; i < 7; i++) begin : g_cnt
    axi4_hs_cnt #(.CW(CNT_WIDTH)) u_cnt (
      .aclk     (aclk),
      .areset_n (areset_n),
      .clr      (clr),
      .inc      (inc[i]),
      .cnt      (cnt[i])
    );
  end

  assign aw_count     = cnt[0];
  assign w_count      = cnt[1];
  assign w_last_count = cnt[2];
  assign b_count      = cnt[3];
  assign ar_count     = cnt[4];
  assign r_count      = cnt[5];
  assign r_last_count = cnt[6];

  axi4_chan_chk #(.W(INFO_W)) u_aw (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clr      (clr),
    .valid    (bus.awvalid),
    .ready    (bus.awready),
    .payload  (bus.awinfo),
    .viol     (violation[0])
  );

  axi4_chan_chk #(.W(WP_W)) u_w (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clr      (clr),
    .valid    (bus.wvalid),
    .ready    (bus.wready),
    .payload  ({bus.wdata, bus.wstrb, bus.wlast}),
    .viol     (violation[1])
  );

  axi4_chan_chk #(.W(BP_W)) u_b (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clr      (clr),
    .valid    (bus.bvalid),
    .ready    (bus.bready),
    .payload  ({bus.bid, bus.bresp}),
    .viol     (violation[2])
  );

  axi4_chan_chk #(.W(INFO_W)) u_ar (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clr      (clr),
    .valid    (bus.arvalid),
    .ready    (bus.arready),
    .payload  (bus.arinfo),
    .viol     (violation[3])
  );

  axi4_chan_chk #(.W(RP_W)) u_r (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clr      (clr),
    .valid    (bus.rvalid),
    .ready    (bus.rready),
    .payload  ({bus.rid, bus.rdata, bus.rresp, bus.rlast}),
    .viol     (violation[4])
  );
endmodule

// File: tb/tb_axi4_handshake_monitor.sv
// Bench for axi4_handshake_monitor: directed table and sequences
// followed by random traffic against a reference model.
module tb_axi4_handshake_monitor;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int CW  = 5;
  localparam int IW  = IDW + AW + 28;
  localparam int PW  = 80;
  localparam int MOD = 1 << CW;

  logic aclk = 1'b0;
  logic areset_n = 1'b1;
  logic clr = 1'b0;
  logic [CW-1:0] cnt_o [7];
  logic [4:0] violation;

  int n_err = 0;
  int n_chk = 0;

  always #5 aclk = ~aclk;

  axi4_handshake_monitor_if #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
  ) bus ();

  axi4_handshake_monitor #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .STRB_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .clr          (clr),
    .bus          (bus.monitor),
    .aw_count     (cnt_o[0]),
    .w_count      (cnt_o[1]),
    .w_last_count (cnt_o[2]),
    .b_count      (cnt_o[3]),
    .ar_count     (cnt_o[4]),
    .r_count      (cnt_o[5]),
    .r_last_count (cnt_o[6]),
    .violation    (violation)
  );

  // ---------------- reference model ----------------
  logic [4:0] vv, rr;
  logic [6:0] ev;
  int unsigned m_cnt [7];
  logic [4:0] m_viol;
  logic m_pend [5];
  logic [PW-1:0] m_snap [5];

  assign vv = {bus.rvalid, bus.arvalid, bus.bvalid, bus.wvalid, bus.awvalid};
  assign rr = {bus.rready, bus.arready, bus.bready, bus.wready, bus.awready};
  assign ev = {vv[4] & rr[4] & bus.rlast, vv[4] & rr[4], vv[3] & rr[3],
               vv[2] & rr[2], vv[1] & rr[1] & bus.wlast, vv[1] & rr[1],
               vv[0] & rr[0]};

  function automatic logic [PW-1:0] pay(int ch);
    case (ch)
      0:       pay = PW'(bus.awinfo);
      1:       pay = PW'({bus.wdata, bus.wstrb, bus.wlast});
      2:       pay = PW'({bus.bid, bus.bresp});
      3:       pay = PW'(bus.arinfo);
      default: pay = PW'({bus.rid, bus.rdata, bus.rresp, bus.rlast});
    endcase
  endfunction

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < 7; i++) m_cnt[i] <= 0;
      m_viol <= '0;
      for (int c = 0; c < 5; c++) begin
        m_pend[c] <= 1'b0;
        m_snap[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 5; c++) m_snap[c] <= pay(c);
      if (clr) begin
        for (int i = 0; i < 7; i++) m_cnt[i] <= 0;
        m_viol <= '0;
        for (int c = 0; c < 5; c++) m_pend[c] <= 1'b0;
      end else begin
        for (int i = 0; i < 7; i++)
          if (ev[i]) m_cnt[i] <= (m_cnt[i] + 1) % MOD;
        for (int c = 0; c < 5; c++) begin
          m_pend[c] <= vv[c] & ~rr[c];
          if (m_pend[c] && (!vv[c] || pay(c) != m_snap[c]))
            m_viol[c] <= 1'b1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s cnt%0d", tag, i), 64'(cnt_o[i]), 64'(m_cnt[i]));
    check({tag, " viol"}, 64'(violation), 64'(m_viol));
  endtask

  task automatic check_zero(string tag);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s cnt%0d", tag, i), 64'(cnt_o[i]), 64'd0);
    check({tag, " viol"}, 64'(violation), 64'd0);
  endtask

  task automatic cyc();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic idle();
    clr = 1'b0;
    bus.awvalid = 0; bus.awready = 0; bus.awinfo = '0;
    bus.wvalid = 0; bus.wready = 0; bus.wlast = 0;
    bus.wdata = '0; bus.wstrb = '0;
    bus.bvalid = 0; bus.bready = 0; bus.bid = '0; bus.bresp = '0;
    bus.arvalid = 0; bus.arready = 0; bus.arinfo = '0;
    bus.rvalid = 0; bus.rready = 0; bus.rlast = 0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
  endtask

  typedef struct {
    logic        v;
    logic        r;
    logic [31:0] addr;
    logic [4:0]  viol;
    logic [CW-1:0] cnt;
  } ar_vec_t;

  ar_vec_t tab [4];
  logic rdy_pat [6];
  bit pd [5];
  bit k [5];

  initial begin
    tab[0] = '{1'b1, 1'b0, 32'h1000, 5'b00000, 5'd0};
    tab[1] = '{1'b1, 1'b0, 32'h1004, 5'b01000, 5'd0};
    tab[2] = '{1'b1, 1'b1, 32'h1004, 5'b01000, 5'd1};
    tab[3] = '{1'b0, 1'b0, 32'h0000, 5'b01000, 5'd1};
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    idle();
    #1 areset_n = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    check_zero("reset");
    areset_n = 1'b1;

    // three back-to-back AW handshakes
    for (int i = 0; i < 3; i++) begin
      bus.awvalid = 1; bus.awready = 1;
      bus.awinfo = IW'(64'h10 + 64'(i));
      cyc();
    end
    idle();
    check("aw3 count", 64'(cnt_o[0]), 64'd3);
    check("aw3 viol", 64'(violation), 64'd0);

    // W burst with ready toggling
    begin
      int beat = 0;
      for (int i = 0; i < 6; i++) begin
        bus.wvalid = 1; bus.wready = rdy_pat[i];
        bus.wdata = DW'(64'hA0 + 64'(beat));
        bus.wstrb = '1; bus.wlast = (beat == 3);
        cyc();
        if (rdy_pat[i]) beat++;
      end
    end
    idle();
    check("w count", 64'(cnt_o[1]), 64'd4);
    check("w last", 64'(cnt_o[2]), 64'd1);
    check("w viol", 64'(violation), 64'd0);

    // AR address changes while pending
    for (int r = 0; r < 4; r++) begin
      bus.arvalid = tab[r].v; bus.arready = tab[r].r;
      bus.arinfo = {4'h0, tab[r].addr, 28'h0};
      cyc();
      check($sformatf("ar row%0d viol", r), 64'(violation), 64'(tab[r].viol));
      check($sformatf("ar row%0d cnt", r), 64'(cnt_o[4]), 64'(tab[r].cnt));
    end
    idle();

    // B valid withdrawn before ready, then clr beats a same-cycle AW
    bus.bvalid = 1; bus.bready = 0; bus.bid = 4'h3;
    cyc();
    bus.bvalid = 0;
    cyc();
    check("b drop viol", 64'(violation), 64'b01100);
    clr = 1; bus.awvalid = 1; bus.awready = 1;
    cyc();
    idle();
    check("clr viol", 64'(violation), 64'd0);
    check("clr b", 64'(cnt_o[3]), 64'd0);
    check("clr aw", 64'(cnt_o[0]), 64'd0);
    check("clr w", 64'(cnt_o[1]), 64'd0);

    // two R bursts, each beat stalls one cycle with stable payload
    for (int b = 0; b < 2; b++) begin
      for (int t = 0; t < 8; t++) begin
        bus.rvalid = 1; bus.rready = 0; bus.rid = IDW'(b);
        bus.rdata = {$urandom(), $urandom()};
        bus.rresp = 2'b00; bus.rlast = (t == 7);
        cyc();
        bus.rready = 1;
        cyc();
      end
    end
    idle();
    check("r count", 64'(cnt_o[5]), 64'd16);
    check("r last", 64'(cnt_o[6]), 64'd2);
    check("r viol", 64'(violation), 64'd0);
    check_model("directed");

    // counter wrap
    clr = 1;
    cyc();
    idle();
    for (int i = 0; i < MOD - 1; i++) begin
      bus.awvalid = 1; bus.awready = 1;
      cyc();
    end
    idle();
    check("wrap full", 64'(cnt_o[0]), 64'(MOD - 1));
    bus.awvalid = 1; bus.awready = 1;
    cyc();
    idle();
    check("wrap zero", 64'(cnt_o[0]), 64'd0);

    // random traffic, mostly protocol-clean
    for (int c = 0; c < 5; c++) pd[c] = 0;
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < 5; c++)
        k[c] = pd[c] && ($urandom_range(0, 24) != 0);
      if (!k[0]) begin
        bus.awvalid = 1'($urandom_range(0, 1));
        bus.awinfo = IW'({$urandom(), $urandom()});
      end
      if (!k[1]) begin
        bus.wvalid = 1'($urandom_range(0, 1));
        bus.wdata = {$urandom(), $urandom()};
        bus.wstrb = SW'($urandom());
        bus.wlast = 1'($urandom_range(0, 1));
      end
      if (!k[2]) begin
        bus.bvalid = 1'($urandom_range(0, 1));
        bus.bid = IDW'($urandom());
        bus.bresp = 2'($urandom());
      end
      if (!k[3]) begin
        bus.arvalid = 1'($urandom_range(0, 1));
        bus.arinfo = IW'({$urandom(), $urandom()});
      end
      if (!k[4]) begin
        bus.rvalid = 1'($urandom_range(0, 1));
        bus.rid = IDW'($urandom());
        bus.rdata = {$urandom(), $urandom()};
        bus.rresp = 2'($urandom());
        bus.rlast = 1'($urandom_range(0, 1));
      end
      bus.awready = 1'($urandom_range(0, 1));
      bus.wready = 1'($urandom_range(0, 1));
      bus.bready = 1'($urandom_range(0, 1));
      bus.arready = 1'($urandom_range(0, 1));
      bus.rready = 1'($urandom_range(0, 1));
      pd[0] = bus.awvalid & ~bus.awready;
      pd[1] = bus.wvalid & ~bus.wready;
      pd[2] = bus.bvalid & ~bus.bready;
      pd[3] = bus.arvalid & ~bus.arready;
      pd[4] = bus.rvalid & ~bus.rready;
      cyc();
      check_model($sformatf("rnd%0d", n));
    end

    // asynchronous reset in the middle of a burst
    idle();
    clr = 1;
    cyc();
    idle();
    bus.awvalid = 1; bus.awready = 1;
    bus.wvalid = 1; bus.wready = 1;
    cyc();
    bus.wvalid = 1; bus.wready = 0;
    cyc();
    check("pre-rst aw", 64'(cnt_o[0]), 64'd2);
    #2 areset_n = 1'b0;
    #1 check_zero("async rst");
    @(negedge aclk);
    idle();
    areset_n = 1'b1;
    cyc();
    check_zero("post rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
